// File: rtl/tpu_pkg.sv
// Shared definitions for the systolic array front end: feeder FSM states
// and sizing helpers used by the feeder and its operand buffer.
package tpu_pkg;

    typedef enum logic [1:0] {
        S_LOAD   = 2'd0,
        S_WAIT   = 2'd1,
        S_STREAM = 2'd2,
        S_DONE   = 2'd3
    } feeder_state_e;

    localparam int DEF_N      = 2;
    localparam int LD_WORDS   = 2 * DEF_N * DEF_N;
    localparam int STREAM_LEN = 2 * DEF_N - 1;

    function automatic int ld_words(input int n);
        return 2 * n * n;
    endfunction

    function automatic int stream_len(input int n);
        return 2 * n - 1;
    endfunction

    // Bits needed to index 0..depth-1; never narrower than one bit.
    function automatic int cnt_w(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/systolic_feeder_operand_buf.sv
// Operand store for one A/B matrix pair: a single write port driven by the
// load index and 2N combinational read ports driven by the skew logic.
module operand_buf
    import tpu_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int N     = 2,
    localparam int DEPTH = ld_words(N),
    localparam int AW    = cnt_w(DEPTH)
) (
    input  logic                          clk,
    input  logic                          i_we,
    input  logic [AW-1:0]                 i_waddr,
    input  logic [WIDTH-1:0]              i_wdata,
    input  logic [2*N-1:0][AW-1:0]        i_raddr,
    output logic [2*N-1:0][WIDTH-1:0]     o_rdata
);

    // Contents are fully rewritten by every load, so no reset is needed.
    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    for (genvar g = 0; g < 2 * N; g++) begin : g_rd
        assign o_rdata[g] = r_mem[i_raddr[g]];
    end

endmodule

// File: rtl/systolic_feeder.sv
// Loads an A/B matrix pair, then drives the west (A rows) and north (B columns)
// edges of an NxN systolic array with diagonally skewed, registered operands.
module systolic_feeder
    import tpu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N     = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     ld_data,
    input  logic                 ld_valid,
    output logic                 ld_ready,
    input  logic                 start,
    output logic [N*WIDTH-1:0]   a_out,
    output logic [N-1:0]         a_valid,
    output logic [N*WIDTH-1:0]   b_out,
    output logic [N-1:0]         b_valid,
    output logic                 busy,
    output logic                 done
);

    localparam int LDW  = ld_words(N);
    localparam int SLEN = stream_len(N);
    localparam int AW   = cnt_w(LDW);
    localparam int TW   = cnt_w(SLEN);

    feeder_state_e              r_state;
    logic [AW-1:0]              r_idx;
    logic [TW-1:0]              r_t;
    logic [N-1:0][WIDTH-1:0]    r_a, r_b;
    logic [N-1:0]               r_av, r_bv;
    logic                       r_done;

    logic                       w_we, w_last, w_go;
    logic [TW-1:0]              w_tn;
    logic [N-1:0]               w_lv;
    logic [2*N-1:0][AW-1:0]     w_raddr;
    logic [2*N-1:0][WIDTH-1:0]  w_rdata;

    assign w_we   = (r_state == S_LOAD) && ld_valid;
    assign w_last = (r_idx == AW'(LDW - 1));

    // w_go/w_tn: whether the coming edge registers a stream step, and which one.
    always_comb begin
        w_go = 1'b0;
        w_tn = '0;
        if (r_state == S_WAIT && start) begin
            w_go = 1'b1;
        end else if (r_state == S_STREAM && r_t != TW'(SLEN - 1)) begin
            w_go = 1'b1;
            w_tn = r_t + TW'(1);
        end
    end

    // Lane g of row/column g is live while 0 <= t-g < N; A[g][t-g] and B[t-g][g].
    for (genvar g = 0; g < N; g++) begin : g_lane
        int w_d;
        assign w_d            = int'(w_tn) - g;
        assign w_lv[g]        = (w_d >= 0) && (w_d < N);
        assign w_raddr[g]     = w_lv[g] ? AW'(g * N + w_d)         : '0;
        assign w_raddr[N + g] = w_lv[g] ? AW'(N * N + w_d * N + g) : '0;
    end

    operand_buf #(.WIDTH(WIDTH), .N(N)) u_buf (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (r_idx),
        .i_wdata (ld_data),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_LOAD;
            r_idx   <= '0;
            r_t     <= '0;
        end else begin
            case (r_state)
                S_LOAD: if (w_we) begin
                    if (w_last) begin
                        r_idx   <= '0;
                        r_state <= S_WAIT;
                    end else begin
                        r_idx <= r_idx + AW'(1);
                    end
                end
                S_WAIT: if (start) begin
                    r_t     <= '0;
                    r_state <= S_STREAM;
                end
                S_STREAM: if (w_go) begin
                    r_t <= w_tn;
                end else begin
                    r_t     <= '0;
                    r_state <= S_DONE;
                end
                S_DONE:  r_state <= S_LOAD;
                default: r_state <= S_LOAD;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a    <= '0;
            r_b    <= '0;
            r_av   <= '0;
            r_bv   <= '0;
            r_done <= 1'b0;
        end else begin
            r_av   <= w_go ? w_lv : '0;
            r_bv   <= w_go ? w_lv : '0;
            r_done <= (r_state == S_STREAM) && !w_go;
            for (int i = 0; i < N; i++) begin
                r_a[i] <= (w_go && w_lv[i]) ? w_rdata[i]     : '0;
                r_b[i] <= (w_go && w_lv[i]) ? w_rdata[N + i] : '0;
            end
        end
    end

    assign a_out    = r_a;
    assign b_out    = r_b;
    assign a_valid  = r_av;
    assign b_valid  = r_bv;
    assign done     = r_done;
    assign ld_ready = (r_state == S_LOAD);
    assign busy     = (r_state != S_LOAD);

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder (N=2, WIDTH=8) with a 2x2 PE array model.
module tb_systolic_feeder;

    localparam int N = 2;
    localparam int W = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [W-1:0]     ld_data = '0;
    logic             ld_valid = 1'b0;
    logic             ld_ready;
    logic             start = 1'b0;
    logic [N*W-1:0]   a_out, b_out;
    logic [N-1:0]     a_valid, b_valid;
    logic             busy, done;

    int errors = 0;
    int checks = 0;

    systolic_feeder #(.WIDTH(W), .N(N)) dut (
        .clk(clk), .rst_n(rst_n), .ld_data(ld_data), .ld_valid(ld_valid),
        .ld_ready(ld_ready), .start(start), .a_out(a_out), .a_valid(a_valid),
        .b_out(b_out), .b_valid(b_valid), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    logic [W-1:0]   vec   [8] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    // Hand-computed stream for A=[[1,2],[3,4]], B=[[5,6],[7,8]]; lane 1 in the upper byte.
    logic [N*W-1:0] exp_a [3] = '{16'h0001, 16'h0302, 16'h0400};
    logic [N*W-1:0] exp_b [3] = '{16'h0005, 16'h0607, 16'h0800};
    logic [N-1:0]   exp_v [3] = '{2'b01, 2'b11, 2'b10};

    // 2x2 output-stationary PE array fed by the feeder edges.
    logic [W-1:0] pa [2][2], pb [2][2], ain [2][2], bin [2][2];
    logic         pav [2][2], pbv [2][2], avin [2][2], bvin [2][2];
    int           acc [2][2];
    bit           pe_clr = 1'b0;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            ain[i][0]  = a_out[i*W +: W];
            avin[i][0] = a_valid[i];
            ain[i][1]  = pa[i][0];
            avin[i][1] = pav[i][0];
            bin[0][i]  = b_out[i*W +: W];
            bvin[0][i] = b_valid[i];
            bin[1][i]  = pb[0][i];
            bvin[1][i] = pbv[0][i];
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                if (pe_clr) begin
                    acc[i][j] <= 0;
                    pav[i][j] <= 1'b0;
                    pbv[i][j] <= 1'b0;
                    pa[i][j]  <= '0;
                    pb[i][j]  <= '0;
                end else begin
                    pa[i][j]  <= ain[i][j];
                    pav[i][j] <= avin[i][j];
                    pb[i][j]  <= bin[i][j];
                    pbv[i][j] <= bvin[i][j];
                    if (avin[i][j] && bvin[i][j])
                        acc[i][j] <= acc[i][j] + int'(ain[i][j]) * int'(bin[i][j]);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic load_all(input string tag, input bit rnd);
        for (int k = 0; k < 8; k++) begin
            if (rnd) begin
                int gap;
                gap = $urandom_range(0, 2);
                for (int g = 0; g < gap; g++) begin
                    ld_valid = 1'b0;
                    ld_data  = W'($urandom);
                    cyc();
                end
            end
            ld_valid = 1'b1;
            ld_data  = vec[k];
            checks++;
            if (ld_ready !== 1'b1) begin
                errors++;
                $display("FAIL %s ld_ready word%0d: got %b exp 1", tag, k, ld_ready);
            end
            cyc();
        end
        ld_valid = 1'b0;
        ld_data  = '0;
    endtask

    task automatic run_stream(input string tag, input bit hold_start);
        start = 1'b1;
        cyc();
        start = hold_start;
        for (int t = 0; t < 3; t++) begin
            checks++;
            if (a_out !== exp_a[t] || a_valid !== exp_v[t]) begin
                errors++;
                $display("FAIL %s t%0d a: got %h/%b exp %h/%b", tag, t, a_out, a_valid, exp_a[t], exp_v[t]);
            end
            checks++;
            if (b_out !== exp_b[t] || b_valid !== exp_v[t]) begin
                errors++;
                $display("FAIL %s t%0d b: got %h/%b exp %h/%b", tag, t, b_out, b_valid, exp_b[t], exp_v[t]);
            end
            checks++;
            if (busy !== 1'b1 || done !== 1'b0 || ld_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s t%0d ctl: got busy=%b done=%b rdy=%b exp 1/0/0", tag, t, busy, done, ld_ready);
            end
            cyc();
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b1 || a_out !== '0 || b_out !== '0 || a_valid !== '0 || b_valid !== '0) begin
            errors++;
            $display("FAIL %s done_cycle: got done=%b busy=%b a=%h b=%h av=%b bv=%b exp 1/1/0/0/0/0",
                     tag, done, busy, a_out, b_out, a_valid, b_valid);
        end
        cyc();
        checks++;
        if (ld_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL %s back_to_load: got rdy=%b busy=%b done=%b exp 1/0/0", tag, ld_ready, busy, done);
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (ld_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset ctl: got rdy=%b busy=%b done=%b exp 1/0/0", ld_ready, busy, done);
        end
        checks++;
        if (a_out !== '0 || b_out !== '0 || a_valid !== '0 || b_valid !== '0) begin
            errors++;
            $display("FAIL reset data: got a=%h b=%h av=%b bv=%b exp 0", a_out, b_out, a_valid, b_valid);
        end
        rst_n = 1'b1;
        cyc();
        checks++;
        if (ld_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset idle: got rdy=%b busy=%b exp 1/0", ld_ready, busy);
        end
    endtask

    task automatic test_load();
        load_all("load", 1'b0);
        checks++;
        if (ld_ready !== 1'b0 || busy !== 1'b1 || done !== 1'b0 || a_valid !== '0) begin
            errors++;
            $display("FAIL load wait: got rdy=%b busy=%b done=%b av=%b exp 0/1/0/0", ld_ready, busy, done, a_valid);
        end
        // Words offered while waiting must not be stored.
        ld_valid = 1'b1;
        ld_data  = 8'hEE;
        cyc();
        cyc();
        checks++;
        if (ld_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL load wait_hold: got rdy=%b busy=%b exp 0/1", ld_ready, busy);
        end
        ld_valid = 1'b0;
        ld_data  = '0;
    endtask

    task automatic test_stream();
        run_stream("stream", 1'b0);
    endtask

    task automatic test_random_load();
        load_all("rndload", 1'b1);
        run_stream("rndload", 1'b0);
    endtask

    task automatic test_start_ignored();
        start = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc();
            checks++;
            if (busy !== 1'b0 || ld_ready !== 1'b1 || a_valid !== '0 || done !== 1'b0) begin
                errors++;
                $display("FAIL start_in_load c%0d: got busy=%b rdy=%b av=%b done=%b exp 0/1/0/0",
                         k, busy, ld_ready, a_valid, done);
            end
        end
        load_all("start_hold", 1'b0);
        run_stream("start_hold", 1'b1);
        start = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc();
            checks++;
            if (busy !== 1'b0 || done !== 1'b0 || a_valid !== '0 || b_valid !== '0) begin
                errors++;
                $display("FAIL start_after c%0d: got busy=%b done=%b av=%b bv=%b exp 0/0/0/0",
                         k, busy, done, a_valid, b_valid);
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset_midstream();
        load_all("rst_mid", 1'b0);
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        checks++;
        if (a_valid !== 2'b11) begin
            errors++;
            $display("FAIL rst_mid at_t1: got av=%b exp 11", a_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (a_out !== '0 || b_out !== '0 || a_valid !== '0 || b_valid !== '0 || done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid async: got a=%h b=%h av=%b bv=%b done=%b busy=%b exp 0",
                     a_out, b_out, a_valid, b_valid, done, busy);
        end
        cyc();
        #2 rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cyc();
            checks++;
            if (done !== 1'b0 || ld_ready !== 1'b1 || busy !== 1'b0) begin
                errors++;
                $display("FAIL rst_mid after c%0d: got done=%b rdy=%b busy=%b exp 0/1/0", k, done, ld_ready, busy);
            end
        end
        load_all("rst_reload", 1'b0);
        run_stream("rst_reload", 1'b0);
    endtask

    task automatic test_pe_array();
        int exp_c [2][2];
        exp_c = '{'{19, 22}, '{43, 50}};
        pe_clr = 1'b1;
        cyc();
        pe_clr = 1'b0;
        load_all("pe", 1'b0);
        run_stream("pe", 1'b0);
        cyc();
        cyc();
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                checks++;
                if (acc[i][j] !== exp_c[i][j]) begin
                    errors++;
                    $display("FAIL pe C[%0d][%0d]: got %0d exp %0d", i, j, acc[i][j], exp_c[i][j]);
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_load();
        test_stream();
        test_random_load();
        test_start_ignored();
        test_reset_midstream();
        test_pe_array();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
